// File: rtl/sec08_queues_accum_pkg.sv
// Shared types and widths for the section-8 group accumulator.
package sec08_queues_accum_pkg;

  localparam int unsigned MSG_W = 32;

  typedef enum logic {
    ACCUM = 1'b0,
    SEND  = 1'b1
  } state_e;

endpackage

// File: rtl/sec08_queues_accum_dpath.sv
// Sum register and adder for the group accumulator.
// Build option: SEC08_QUEUES_ACCUM_SATURATE_EN clamps the running sum at
// all-ones instead of wrapping modulo 2^32.
module sec08_queues_accum_dpath
  import sec08_queues_accum_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_first,
  input  logic             add_en,
  input  logic             clear,
  input  logic [MSG_W-1:0] msg,
  output logic [MSG_W-1:0] sum
);

  logic [MSG_W-1:0] add_res;

`ifdef SEC08_QUEUES_ACCUM_SATURATE_EN
  logic [MSG_W:0] add_full;

  // Widened add; a carry out clamps to all-ones. Once clamped, any further
  // add carries again (or adds zero), so saturation holds for the group.
  always_comb begin
    add_full = {1'b0, sum} + {1'b0, msg};
    add_res  = add_full[MSG_W] ? '1 : add_full[MSG_W-1:0];
  end
`else
  // Plain modulo-2^32 add.
  always_comb begin
    add_res = sum + msg;
  end
`endif

  // Sum register: first message of a group loads, later ones accumulate.
  // NOTE: reset is synchronous and state uses non-blocking assignments so
  // every register samples the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum <= '0;
    end else if (load_first) begin
      sum <= msg;
    end else if (add_en) begin
      sum <= add_res;
    end
  end

endmodule

// File: rtl/sec08_queues_group_accum.sv
// Group accumulator: sums each run of p_group_nmsgs input messages and emits
// one sum per group. Holds the input off while a finished sum is pending.
// Build option: SEC08_QUEUES_ACCUM_SATURATE_EN (saturating add, see dpath).
module sec08_queues_group_accum
  import sec08_queues_accum_pkg::*;
#(
  parameter int unsigned p_group_nmsgs = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [MSG_W-1:0] istream_msg,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [MSG_W-1:0] ostream_msg
);

  localparam int unsigned          CNT_W    = $clog2(p_group_nmsgs + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(p_group_nmsgs - 1);

  state_e           state;
  logic [CNT_W-1:0] count;
  logic             in_fire;
  logic             out_fire;
  logic             load_first;
  logic             add_en;

  // Handshake decode; input is held off during reset so nothing is lost.
  always_comb begin
    istream_rdy = (state == ACCUM) && !reset;
    ostream_val = (state == SEND);
    in_fire     = istream_val && istream_rdy;
    out_fire    = ostream_val && ostream_rdy;
    load_first  = in_fire && (count == '0);
    add_en      = in_fire && (count != '0);
  end

  sec08_queues_accum_dpath u_dpath (
    .clk        (clk),
    .reset      (reset),
    .load_first (load_first),
    .add_en     (add_en),
    .clear      (out_fire),
    .msg        (istream_msg),
    .sum        (ostream_msg)
  );

  // Control FSM and message counter; count wraps to zero on the last message.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
      count <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_fire) begin
            if (count == CNT_LAST) begin
              count <= '0;
              state <= SEND;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        SEND: begin
          if (out_fire) begin
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sec08_queues_group_accum.sv
// Bench for sec08_queues_group_accum: a 4-message instance driven from a
// vector table plus hand sequences, and a 1-message instance. Expected sums
// go into scoreboard queues as stimulus is driven and are popped on output.
module tb_sec08_queues_group_accum;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        a_istream_val = 1'b0;
  logic        a_istream_rdy;
  logic [31:0] a_istream_msg = '0;
  logic        a_ostream_val;
  logic        a_ostream_rdy = 1'b1;
  logic [31:0] a_ostream_msg;

  logic        b_istream_val = 1'b0;
  logic        b_istream_rdy;
  logic [31:0] b_istream_msg = '0;
  logic        b_ostream_val;
  logic        b_ostream_rdy = 1'b1;
  logic [31:0] b_ostream_msg;

  always #5 clk = ~clk;

  sec08_queues_group_accum #(.p_group_nmsgs(4)) dut_a (
    .clk(clk), .reset(reset),
    .istream_val(a_istream_val), .istream_rdy(a_istream_rdy), .istream_msg(a_istream_msg),
    .ostream_val(a_ostream_val), .ostream_rdy(a_ostream_rdy), .ostream_msg(a_ostream_msg)
  );

  sec08_queues_group_accum #(.p_group_nmsgs(1)) dut_b (
    .clk(clk), .reset(reset),
    .istream_val(b_istream_val), .istream_rdy(b_istream_rdy), .istream_msg(b_istream_msg),
    .ostream_val(b_ostream_val), .ostream_rdy(b_ostream_rdy), .ostream_msg(b_ostream_msg)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] sum;
    int          hold;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];

  // Scoreboard / protocol monitor, sampled on the falling edge.
  int ncyc = 0;
  int a_last_fire = -10;
  int a_vcnt = 0;
  int a_outs = 0;
  int b_last_fire = -10;
  int b_fires = 0;
  int b_outs = 0;

  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      // Instance A: 4-message groups, per-group output stall.
      if (a_ostream_val && !reset) begin
        if (a_q.size() == 0) begin
          check("a_spurious_out", {31'b0, a_ostream_val}, 32'd0);
        end else begin
          if (a_vcnt == 0) check("a_latency", ncyc, a_last_fire + 1);
          check("a_rdy_low_in_send", {31'b0, a_istream_rdy}, 32'd0);
          check("a_sum", a_ostream_msg, a_q[0].sum);
          if (a_vcnt >= a_q[0].hold) begin
            a_ostream_rdy = 1'b1;
            void'(a_q.pop_front());
            a_outs++;
            a_vcnt = 0;
          end else begin
            a_ostream_rdy = 1'b0;
            a_vcnt++;
          end
        end
      end else begin
        a_ostream_rdy = 1'b1;
        a_vcnt = 0;
      end
      if (a_istream_val && a_istream_rdy) a_last_fire = ncyc;

      // Instance B: single-message groups, downstream always ready.
      if (b_ostream_val && !reset) begin
        if (b_q.size() == 0) begin
          check("b_spurious_out", {31'b0, b_ostream_val}, 32'd0);
        end else begin
          check("b_latency", ncyc, b_last_fire + 1);
          check("b_rdy_low_in_send", {31'b0, b_istream_rdy}, 32'd0);
          check("b_sum", b_ostream_msg, b_q[0].sum);
          void'(b_q.pop_front());
          b_outs++;
        end
      end
      if (b_istream_val && b_istream_rdy) begin
        if (b_fires > 0) check("b_fire_interval", ncyc - b_last_fire, 32'd2);
        b_last_fire = ncyc;
        b_fires++;
      end
    end
  end

  // Present one message to A and hold it until accepted (bounded wait).
  task automatic send_a(input logic [31:0] m, input int gap);
    int n;
    n = 0;
    a_istream_val = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    a_istream_val = 1'b1;
    a_istream_msg = m;
    @(negedge clk);
    while (!a_istream_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("a_in_accept_timeout", {31'b0, a_istream_rdy}, 32'd1);
    @(posedge clk); #1;
    a_istream_val = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] m);
    int n;
    n = 0;
    b_istream_val = 1'b1;
    b_istream_msg = m;
    @(negedge clk);
    while (!b_istream_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("b_in_accept_timeout", {31'b0, b_istream_rdy}, 32'd1);
    @(posedge clk); #1;
    b_istream_val = 1'b0;
  endtask

  typedef struct {
    logic [3:0][31:0] msg;
    logic [3:0][3:0]  gap;
    int               hold;
    logic [31:0]      exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    vecs[0] = '{msg: {32'd4, 32'd3, 32'd2, 32'd1}, gap: {4'd0, 4'd0, 4'd0, 4'd0}, hold: 0, exp: 32'd10};
    vecs[1] = '{msg: {32'd5, 32'd5, 32'd5, 32'd5}, gap: {4'd0, 4'd0, 4'd0, 4'd0}, hold: 3, exp: 32'd20};
    vecs[2] = '{msg: {32'd1, 32'd0, 32'd0, 32'd7}, gap: {4'd0, 4'd0, 4'd0, 4'd0}, hold: 0, exp: 32'd8};
    vecs[3] = '{msg: {32'd40, 32'd30, 32'd20, 32'd10}, gap: {4'd1, 4'd3, 4'd0, 4'd2}, hold: 0, exp: 32'd100};
`ifdef SEC08_QUEUES_ACCUM_SATURATE_EN
    vecs[4] = '{msg: {32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF}, gap: {4'd0, 4'd0, 4'd0, 4'd0}, hold: 0, exp: 32'hFFFF_FFFF};
`else
    vecs[4] = '{msg: {32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF}, gap: {4'd0, 4'd0, 4'd0, 4'd0}, hold: 0, exp: 32'h0000_0001};
`endif

    // Reset state while reset is asserted, then the first cycle after.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_istream_rdy", {31'b0, a_istream_rdy}, 32'd0);
    check("rst_a_ostream_val", {31'b0, a_ostream_val}, 32'd0);
    check("rst_b_istream_rdy", {31'b0, b_istream_rdy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_a_istream_rdy", {31'b0, a_istream_rdy}, 32'd1);
    check("post_rst_a_ostream_val", {31'b0, a_ostream_val}, 32'd0);
    check("post_rst_a_sum", a_ostream_msg, 32'd0);
    check("post_rst_b_istream_rdy", {31'b0, b_istream_rdy}, 32'd1);
    @(posedge clk); #1;

    // Table-driven groups, expected sum queued before the group's last message.
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 3) a_q.push_back('{sum: vecs[v].exp, hold: vecs[v].hold});
        send_a(vecs[v].msg[k], int'(vecs[v].gap[k]));
      end
    end

    n = 0;
    while (a_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("a_table_drain", a_q.size(), 32'd0);

    // Reset mid-group discards the partial sum of 9+9.
    send_a(32'd9, 0);
    send_a(32'd9, 0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_a_istream_rdy", {31'b0, a_istream_rdy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("mid_rst_no_output_outs", a_outs, 32'd5);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) a_q.push_back('{sum: 32'd4, hold: 0});
      send_a(32'd1, 0);
    end

    // Single-message groups: 42 then 43 back-to-back.
    b_q.push_back('{sum: 32'd42, hold: 0});
    send_b(32'd42);
    b_q.push_back('{sum: 32'd43, hold: 0});
    send_b(32'd43);

    n = 0;
    while ((a_q.size() != 0 || b_q.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("a_drain", a_q.size(), 32'd0);
    check("b_drain", b_q.size(), 32'd0);
    check("a_output_count", a_outs, 32'd6);
    check("b_output_count", b_outs, 32'd2);
    check("b_input_count", b_fires, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sec08_queues_group_accum.md
# sec08_queues_group_accum

- Stream-processing stage placed directly downstream of the two-entry normal queue in the section-8 queue pipeline.
- Consumes 32-bit messages from the queue's output stream and sums each consecutive group of `p_group_nmsgs` messages.
- Emits one 32-bit sum per group on its own output stream.
- Exercises back-pressure into the queue: the queue fills while this stage holds a completed sum.

## Interface
Parameters:
- `p_group_nmsgs`, default 4: messages per group; legal range 1..255.

Ports:
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `istream_val`  input  1  upstream message valid (driven by queue `ostream_val`).
- `istream_rdy`  output  1  this block accepts a message this cycle.
- `istream_msg`  input  32  unsigned addend.
- `ostream_val`  output  1  group sum valid.
- `ostream_rdy`  input  1  downstream accepts sum.
- `ostream_msg`  output  32  group sum.

## Operation
- Two-state FSM: ACCUM, SEND.
- ACCUM:
  - `istream_rdy`=1, `ostream_val`=0.
  - On input fire (`istream_val` && `istream_rdy`): if count==0, sum<=msg; else sum<=sum+msg. count<=count+1.
  - Fire with count==p_group_nmsgs-1: transition to SEND; count<=0.
- SEND:
  - `istream_rdy`=0, `ostream_val`=1, `ostream_msg`=sum.
  - Sum held stable while `ostream_rdy`=0.
  - On output fire: transition to ACCUM; sum<=0.
- Counter width: $clog2(p_group_nmsgs+1) bits; never exceeds p_group_nmsgs-1.
- Addition is unsigned 32-bit. Overflow behaviour is set by the configuration macro.
- `ostream_msg` is driven from the sum register in every state. It is meaningful only when `ostream_val`=1.
- p_group_nmsgs==1: every accepted message goes directly to SEND with sum=msg.

## Timing
- Reset (while `reset`=1 and the cycle after): state=ACCUM, count=0, sum=0, `ostream_val`=0. `istream_rdy`=0 while reset is asserted, then 1 in the first cycle after deassertion.
- Reset mid-group or in SEND: partial sum and pending output are discarded; no output fires.
- Latency: sum valid the cycle after the group's last input fire.
- Throughput: one group per p_group_nmsgs+1 cycles at best. The SEND cycle is a one-cycle bubble on the input.
- Inputs arriving while in SEND are back-pressured (`istream_rdy`=0) and never dropped.
- Input and output never fire in the same cycle.
- Input gaps (`istream_val`=0) in ACCUM stall the count without altering sum.

## Configuration
- `SEC08_QUEUES_ACCUM_SATURATE_EN`:
  - Defined: if a 33-bit add result exceeds 32'hFFFF_FFFF, sum<=32'hFFFF_FFFF. Saturation is sticky for the rest of the group.
  - Undefined: sum wraps modulo 2^32.
- Handshake timing is identical in both builds.

## Structure
- Package `sec08_queues_accum_pkg`:
  - state enum typedef (ACCUM=1'b0, SEND=1'b1);
  - localparam for message width (32).
- Sub-module `sec08_queues_accum_dpath`:
  - sum register, adder, saturation mux under the macro;
  - controls: load_first, add_en, clear.
- Top level holds the FSM, counter and handshake logic, and instantiates the datapath.

## Test plan
- p_group_nmsgs=4; inputs 1,2,3,4 back-to-back; `ostream_rdy`=1 -> single output 10 exactly one cycle after the 4th fire; `istream_rdy`=0 during that cycle.
- Two groups (5,5,5,5 then 7,0,0,1) with `ostream_rdy` held 0 for 3 cycles after the first sum -> output 20 held stable 4 cycles; `istream_rdy`=0 throughout; then output 8.
- Random `istream_val` gaps on inputs 10,20,30,40 -> output 100; count unaffected by idle cycles.
- Inputs 0xFFFF_FFFF,2,0,0 -> output 0x0000_0001 without the macro; 0xFFFF_FFFF with `SEC08_QUEUES_ACCUM_SATURATE_EN`.
- Reset asserted after 2 of 4 inputs (9,9) -> no output. Next group 1,1,1,1 -> output 4.
- p_group_nmsgs=1; inputs 42,43 -> outputs 42,43; alternating accept/send cycles.
